// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package regfile_arb_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_e;

    // Highest register index touched by the clear sweep (register 0 stays untouched).
    function automatic int clear_last(input int aw);
        return (1 << aw) - 1;
    endfunction

    function automatic int grant_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-clear sweep after reset, then
// round-robin arbitration between NUM_REQ writeback requesters.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REQ       = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               we_o,
    output logic [ADDRESS_WIDTH-1:0]           waddr_o,
    output logic [DATA_WIDTH-1:0]              wdata_o,
    output logic [grant_width(NUM_REQ)-1:0]    grant_id_o,
    output logic                               busy_o
);

    localparam int GW = grant_width(NUM_REQ);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(clear_last(ADDRESS_WIDTH));

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] clear_ptr;
    logic [GW-1:0]            rr_ptr;

    logic [NUM_REQ-1:0]       grant;
    logic [GW-1:0]            grant_idx;
    logic                     any_grant;
    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Only valid reaches ready combinationally; addr/data are used solely into registers.
    assign req_ready_o = (state == ST_ARB) ? grant : '0;
    assign accept      = (state == ST_ARB) && any_grant;
    assign sel_addr    = req_addr_i[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_data    = req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // NOTE: asynchronous reset clears every state register, so a mid-sweep reset abandons any in-flight write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_CLEAR;
            clear_ptr  <= ADDRESS_WIDTH'(1);
            rr_ptr     <= '0;
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            grant_id_o <= '0;
            busy_o     <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    we_o      <= 1'b1;
                    waddr_o   <= clear_ptr;
                    wdata_o   <= '0;
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == LAST_ADDR) begin
                        state  <= ST_ARB;
                        busy_o <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (accept) begin
                        // Writes to register 0 are accepted but dropped.
                        we_o       <= (sel_addr != '0);
                        waddr_o    <= sel_addr;
                        wdata_o    <= sel_data;
                        grant_id_o <= grant_idx;
                        rr_ptr     <= (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end else begin
                        we_o <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter at default parameters.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [1:0]       grant_id;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    ready;
        logic             we;
        logic [AW-1:0]    waddr;
        logic [DW-1:0]    wdata;
        logic [1:0]       gid;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] r, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [1:0] g);
        vec_t x;
        x.valid = v;
        x.addr  = {a2, a1, a0};
        x.data  = {d2, d1, d0};
        x.ready = r;
        x.we    = w;
        x.waddr = wa;
        x.wdata = wd;
        x.gid   = g;
        return x;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    64'(we),        64'(0));
        check({tag, "_waddr"}, 64'(waddr),     64'(0));
        check({tag, "_wdata"}, 64'(wdata),     64'(0));
        check({tag, "_gid"},   64'(grant_id),  64'(0));
        check({tag, "_busy"},  64'(busy),      64'(1));
        check({tag, "_ready"}, 64'(req_ready), 64'(0));
    endtask

    // Entered just after reset release; ends #1 after the edge that shows waddr==last.
    task automatic do_sweep(input int last, input logic [NR-1:0] ready_after_last);
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sweep_we_%0d", i),    64'(we),    64'(1));
            check($sformatf("sweep_waddr_%0d", i), 64'(waddr), 64'(i));
            check($sformatf("sweep_wdata_%0d", i), 64'(wdata), 64'(0));
            check($sformatf("sweep_busy_%0d", i),  64'(busy),  64'(i < 31));
            check($sformatf("sweep_ready_%0d", i), 64'(req_ready),
                  (i == 31) ? 64'(ready_after_last) : 64'(0));
        end
    endtask

    logic [NR-1:0]    prev_valid;
    logic [NR-1:0]    prev_ready;
    logic [NR*AW-1:0] prev_addr;
    logic [NR*DW-1:0] prev_data;

    initial begin
        vecs[0]  = mk(3'b010, 0, 5, 0,  0, 32'hDEADBEEF, 0,  3'b010, 1, 5, 32'hDEADBEEF, 1);
        vecs[1]  = mk(3'b100, 0, 0, 7,  0, 0, 32'h77,        3'b100, 1, 7, 32'h77, 2);
        vecs[2]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 10, 32'hA0, 0);
        vecs[3]  = mk(3'b111, 13, 11, 12, 32'hB0, 32'hA1, 32'hA2, 3'b010, 1, 11, 32'hA1, 1);
        vecs[4]  = mk(3'b111, 13, 14, 12, 32'hB0, 32'hB1, 32'hA2, 3'b100, 1, 12, 32'hA2, 2);
        vecs[5]  = mk(3'b111, 13, 14, 15, 32'hB0, 32'hB1, 32'hB2, 3'b001, 1, 13, 32'hB0, 0);
        vecs[6]  = mk(3'b111, 16, 14, 15, 32'hC0, 32'hB1, 32'hB2, 3'b010, 1, 14, 32'hB1, 1);
        vecs[7]  = mk(3'b111, 16, 17, 15, 32'hC0, 32'hC1, 32'hB2, 3'b100, 1, 15, 32'hB2, 2);
        vecs[8]  = mk(3'b011, 16, 17, 0,  32'hC0, 32'hC1, 0,      3'b001, 1, 16, 32'hC0, 0);
        vecs[9]  = mk(3'b010, 0, 17, 0,   0, 32'hC1, 0,           3'b010, 1, 17, 32'hC1, 1);
        vecs[10] = mk(3'b100, 0, 0, 0,    0, 0, 32'h1234,         3'b100, 0, 0, 32'h1234, 2);
        vecs[11] = mk(3'b101, 20, 0, 21,  32'h20, 0, 32'h21,      3'b001, 1, 20, 32'h20, 0);
        vecs[12] = mk(3'b100, 0, 0, 21,   0, 0, 32'h21,           3'b100, 1, 21, 32'h21, 2);
        vecs[13] = mk(3'b000, 0, 0, 0,    0, 0, 0,                3'b000, 0, 21, 32'h21, 2);

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        prev_valid = '0;
        prev_ready = '0;
        prev_addr  = '0;
        prev_data  = '0;

        // Reset then idle sweep.
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        do_sweep(31, 3'b000);
        @(posedge clk);
        #1;
        check("idle_we_after_sweep",   64'(we),   64'(0));
        check("idle_busy_after_sweep", 64'(busy), 64'(0));

        // Table-driven ARB vectors, one accepted write per cycle.
        @(negedge clk);
        for (int v = 0; v < 14; v++) begin
            for (int i = 0; i < NR; i++) begin
                if (prev_valid[i] && !prev_ready[i]) begin
                    check($sformatf("hold_v%0d_r%0d", v, i),
                          {31'(0), vecs[v].valid[i], vecs[v].addr[i*AW +: AW], vecs[v].data[i*DW +: DW]},
                          {31'(0), 1'b1, prev_addr[i*AW +: AW], prev_data[i*DW +: DW]});
                end
            end
            req_valid = vecs[v].valid;
            req_addr  = vecs[v].addr;
            req_data  = vecs[v].data;
            #1;
            check($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].ready));
            prev_valid = req_valid;
            prev_ready = req_ready;
            prev_addr  = req_addr;
            prev_data  = req_data;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", v),    64'(we),       64'(vecs[v].we));
            check($sformatf("v%0d_waddr", v), 64'(waddr),    64'(vecs[v].waddr));
            check($sformatf("v%0d_wdata", v), 64'(wdata),    64'(vecs[v].wdata));
            check($sformatf("v%0d_gid", v),   64'(grant_id), 64'(vecs[v].gid));
            @(negedge clk);
        end

        // Reset mid-sweep at waddr 12, with requester 0 waiting through the restarted sweep.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_sweep(12, 3'b000);
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd9};
        req_data  = {32'h0, 32'h0, 32'h99};
        #1;
        check("midreset_ready_held_low", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        do_sweep(31, 3'b001);
        @(posedge clk);
        #1;
        check("clearreq_we",    64'(we),       64'(1));
        check("clearreq_waddr", 64'(waddr),    64'(9));
        check("clearreq_wdata", 64'(wdata),    64'(32'h99));
        check("clearreq_gid",   64'(grant_id), 64'(0));
        req_valid = '0;
        @(posedge clk);
        #1;
        check("clearreq_we_after", 64'(we), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
